// File: rtl/pixie_pkg.sv
// Shared constants and types for the pixie video responder.
// Holds the frame-window line numbers, the machine-cycle windows, the CPU
// state-code encodings and the timing decode bundle passed from pixie_timing.
package pixie_pkg;

  // Counter widths for the default 8 x 14 x 262 geometry.
  localparam int unsigned CDIV_W    = 3;
  localparam int unsigned MCYC_W    = 4;
  localparam int unsigned LINE_W    = 9;
  localparam int unsigned BYTECNT_W = 4;
  localparam int unsigned PIXCNT_W  = 3;

  // Line numbers bounding the request windows.
  localparam int unsigned LN_EF1_A    = 76;
  localparam int unsigned LN_INT      = 78;
  localparam int unsigned LN_DISP     = 80;
  localparam int unsigned LN_EF1_B    = 204;
  localparam int unsigned LN_DISP_END = 208;
  localparam int unsigned VSYNC_LINES = 4;

  // Machine-cycle window bounds within a line.
  localparam int unsigned MC_DMA_START = 2;
  localparam int unsigned MC_DMA_END   = 10;
  localparam int unsigned MC_HSYNC     = 12;

  localparam int unsigned BYTES_PER_LINE = 8;

  // CPU state codes.
  localparam logic [1:0] SC_DMA = 2'b10;
  localparam logic [1:0] SC_INT = 2'b11;

  // Decodes of the current counter position.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic disp_line;
    logic int_line;
    logic ef1_line;
    logic dma_win;
    logic line_end;
  } timing_t;

endpackage

// File: rtl/pixie_timing.sv
// Free-running frame timing for pixie_video.
// Ports: CLOCK/CLEAR_N (sync active-low reset); tim_c = combinational decodes
// of the cdiv/mcyc/line counters (syncs, line windows, DMA window, line end).
module pixie_timing
  import pixie_pkg::*;
#(
  parameter int unsigned CYC_CLKS    = 8,
  parameter int unsigned LINE_CYCS   = 14,
  parameter int unsigned FRAME_LINES = 262,
  parameter int unsigned DISP_FIRST  = 80,
  parameter int unsigned DISP_LINES  = 128
) (
  input  logic    CLOCK,
  input  logic    CLEAR_N,
  output timing_t tim_c
);

  logic [CDIV_W-1:0] cdiv_q, cdiv_d;
  logic [MCYC_W-1:0] mcyc_q, mcyc_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              cdiv_last, mcyc_last, line_last;

  assign cdiv_last = (cdiv_q == CDIV_W'(CYC_CLKS - 1));
  assign mcyc_last = (mcyc_q == MCYC_W'(LINE_CYCS - 1));
  assign line_last = (line_q == LINE_W'(FRAME_LINES - 1));

  // Cascaded counter advance.
  always_comb begin
    cdiv_d = cdiv_q + CDIV_W'(1);
    mcyc_d = mcyc_q;
    line_d = line_q;
    if (cdiv_last) begin
      cdiv_d = '0;
      if (mcyc_last) begin
        mcyc_d = '0;
        line_d = line_last ? '0 : line_q + LINE_W'(1);
      end else begin
        mcyc_d = mcyc_q + MCYC_W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!CLEAR_N) begin
      cdiv_q <= '0;
      mcyc_q <= '0;
      line_q <= '0;
    end else begin
      cdiv_q <= cdiv_d;
      mcyc_q <= mcyc_d;
      line_q <= line_d;
    end
  end

  // Window decodes of the present position; the consumer registers them.
  always_comb begin
    tim_c           = '0;
    tim_c.hsync     = (mcyc_q >= MCYC_W'(MC_HSYNC));
    tim_c.vsync     = (line_q < LINE_W'(VSYNC_LINES));
    tim_c.disp_line = (line_q >= LINE_W'(DISP_FIRST)) &&
                      (line_q < LINE_W'(DISP_FIRST + DISP_LINES));
    tim_c.int_line  = (line_q >= LINE_W'(LN_INT)) && (line_q < LINE_W'(LN_DISP));
    tim_c.ef1_line  = ((line_q >= LINE_W'(LN_EF1_A)) && (line_q < LINE_W'(LN_DISP))) ||
                      ((line_q >= LINE_W'(LN_EF1_B)) && (line_q < LINE_W'(LN_DISP_END)));
    tim_c.dma_win   = (mcyc_q >= MCYC_W'(MC_DMA_START)) && (mcyc_q < MCYC_W'(MC_DMA_END));
    tim_c.line_end  = cdiv_last && mcyc_last;
  end

endmodule

// File: rtl/pixie_video.sv
// CDP1861-style video responder.
// Ports: CLOCK/CLEAR_N (sync active-low reset); SC, dma_data, dma_strobe,
// io_n, io_inp, io_out from the CPU; dma_out_req, int_n, ef1_n requests back
// to the CPU; pixel/hsync/vsync/de to the video mixer. All outputs are flops.
// CYC_CLKS must be 8 (one DMA byte is serialised per machine cycle).
module pixie_video
  import pixie_pkg::*;
#(
  parameter int unsigned CYC_CLKS    = 8,
  parameter int unsigned LINE_CYCS   = 14,
  parameter int unsigned FRAME_LINES = 262,
  parameter int unsigned DISP_FIRST  = 80,
  parameter int unsigned DISP_LINES  = 128
) (
  input  logic       CLOCK,
  input  logic       CLEAR_N,
  input  logic [1:0] SC,
  input  logic [7:0] dma_data,
  input  logic       dma_strobe,
  input  logic [2:0] io_n,
  input  logic       io_inp,
  input  logic       io_out,
  output logic       dma_out_req,
  output logic       int_n,
  output logic       ef1_n,
  output logic       pixel,
  output logic       hsync,
  output logic       vsync,
  output logic       de
);

  timing_t tim;

  pixie_timing #(
    .CYC_CLKS    (CYC_CLKS),
    .LINE_CYCS   (LINE_CYCS),
    .FRAME_LINES (FRAME_LINES),
    .DISP_FIRST  (DISP_FIRST),
    .DISP_LINES  (DISP_LINES)
  ) u_timing (
    .CLOCK   (CLOCK),
    .CLEAR_N (CLEAR_N),
    .tim_c   (tim)
  );

  logic                 en_q, en_d;
  logic [BYTECNT_W-1:0] bytecnt_q, bytecnt_d, bytecnt_acc;
  logic [7:0]           shifter_q, shifter_d;
  logic [PIXCNT_W-1:0]  pixcnt_q, pixcnt_d;
  logic                 live_q, live_d;
  logic                 int_done_q, int_done_d;
  logic                 dma_out_req_q, dma_out_req_d;
  logic                 int_n_q, int_n_d;
  logic                 ef1_n_q, ef1_n_d;
  logic                 hsync_q, hsync_d;
  logic                 vsync_q, vsync_d;
  logic                 de_q, de_d;
  logic                 accept, sc_int, io_sel;

  assign io_sel = (io_n == 3'd1);
  assign sc_int = (SC == SC_INT);
  // A byte counts only while the responder is actually requesting it.
  assign accept = dma_strobe && (SC == SC_DMA) && dma_out_req_q;

  // Display enable: a clear beats a simultaneous set.
  always_comb begin
    en_d = en_q;
    if (io_sel && io_out) begin
      en_d = 1'b0;
    end else if (io_sel && io_inp) begin
      en_d = 1'b1;
    end
  end

  // Per-line byte count; the request looks at the post-accept count so it
  // drops in the clock right after the last byte.
  always_comb begin
    bytecnt_acc   = accept ? bytecnt_q + BYTECNT_W'(1) : bytecnt_q;
    bytecnt_d     = tim.line_end ? '0 : bytecnt_acc;
    dma_out_req_d = en_q && tim.disp_line && tim.dma_win &&
                    (bytecnt_acc < BYTECNT_W'(BYTES_PER_LINE));
  end

  // Interrupt: one request per frame, released by the first acknowledge.
  always_comb begin
    int_done_d = tim.int_line ? (int_done_q || sc_int) : 1'b0;
    int_n_d    = !(en_q && tim.int_line && !int_done_q && !sc_int);
    ef1_n_d    = !(en_q && tim.ef1_line);
    de_d       = en_q && tim.disp_line && tim.dma_win;
    hsync_d    = tim.hsync;
    vsync_d    = tim.vsync;
  end

  // Serialiser: zero fill means the shifter is empty once a byte is done,
  // so shifter[7] alone is the pixel. A load always wins over the shift.
  always_comb begin
    shifter_d = shifter_q;
    pixcnt_d  = pixcnt_q;
    live_d    = live_q;
    if (accept) begin
      shifter_d = dma_data;
      pixcnt_d  = PIXCNT_W'(7);
      live_d    = 1'b1;
    end else if (live_q) begin
      shifter_d = {shifter_q[6:0], 1'b0};
      if (pixcnt_q == '0) begin
        live_d = 1'b0;
      end else begin
        pixcnt_d = pixcnt_q - PIXCNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!CLEAR_N) begin
      en_q          <= 1'b0;
      bytecnt_q     <= '0;
      shifter_q     <= '0;
      pixcnt_q      <= '0;
      live_q        <= 1'b0;
      int_done_q    <= 1'b0;
      dma_out_req_q <= 1'b0;
      int_n_q       <= 1'b1;
      ef1_n_q       <= 1'b1;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b1;
      de_q          <= 1'b0;
    end else begin
      en_q          <= en_d;
      bytecnt_q     <= bytecnt_d;
      shifter_q     <= shifter_d;
      pixcnt_q      <= pixcnt_d;
      live_q        <= live_d;
      int_done_q    <= int_done_d;
      dma_out_req_q <= dma_out_req_d;
      int_n_q       <= int_n_d;
      ef1_n_q       <= ef1_n_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
    end
  end

  assign dma_out_req = dma_out_req_q;
  assign int_n       = int_n_q;
  assign ef1_n       = ef1_n_q;
  assign pixel       = shifter_q[7];
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;

endmodule

// File: tb/tb_pixie_video.sv
// Self-checking bench for pixie_video: a frame-arithmetic reference model
// checks every output every clock, plus a table of frame-position vectors and
// hand-written sequences for the DMA, interrupt and reset corner cases.
module tb_pixie_video;

  localparam int FRAME_CLKS = 262 * 14 * 8;

  logic       CLOCK = 1'b0;
  logic       CLEAR_N;
  logic [1:0] SC;
  logic [7:0] dma_data;
  logic       dma_strobe;
  logic [2:0] io_n;
  logic       io_inp;
  logic       io_out;
  logic       dma_out_req, int_n, ef1_n, pixel, hsync, vsync, de;

  pixie_video dut (
    .CLOCK       (CLOCK),
    .CLEAR_N     (CLEAR_N),
    .SC          (SC),
    .dma_data    (dma_data),
    .dma_strobe  (dma_strobe),
    .io_n        (io_n),
    .io_inp      (io_inp),
    .io_out      (io_out),
    .dma_out_req (dma_out_req),
    .int_n       (int_n),
    .ef1_n       (ef1_n),
    .pixel       (pixel),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de)
  );

  always #5 CLOCK = ~CLOCK;

  int total = 0;
  int bad   = 0;

  // Reference model state: position is just clocks since reset.
  int  m_n;
  bit  m_en;
  int  m_bytes;
  bit  m_req;
  int  m_ack;
  bit  pq[$];
  bit  e_req, e_int_n, e_ef1_n, e_pix, e_hs, e_vs, e_de;

  typedef struct {
    int ln; int mc; int cd;
    bit hs; bit vs; bit ef1_n; bit int_n; bit de; bit req;
  } vec_t;
  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at clk %0d", nm, act, exp, m_n);
    end
  endtask

  task automatic chkn(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at clk %0d", nm, act, exp, m_n);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_en = 0; m_bytes = 0; m_req = 0; m_ack = -1;
    pq.delete();
    e_req = 0; e_int_n = 1; e_ef1_n = 1; e_pix = 0; e_hs = 0; e_vs = 1; e_de = 0;
  endtask

  // One clock edge of the behavioural model, using the inputs the DUT saw.
  task automatic model_edge();
    int ln, mc, cd, f;
    bit acc, win_int, disp, win_dma;
    if (!CLEAR_N) begin
      model_reset();
      return;
    end
    cd = m_n % 8;
    mc = (m_n / 8) % 14;
    ln = (m_n / 112) % 262;
    f  = m_n / FRAME_CLKS;
    acc = dma_strobe && (SC == 2'b10) && m_req;
    if (acc) begin
      m_bytes++;
      pq.delete();
      for (int i = 7; i >= 0; i--) pq.push_back(dma_data[i]);
    end
    e_pix   = (pq.size() > 0) ? pq.pop_front() : 1'b0;
    disp    = (ln >= 80) && (ln < 208);
    win_dma = (mc >= 2) && (mc < 10);
    e_req   = m_en && disp && win_dma && (m_bytes < 8);
    m_req   = e_req;
    if (cd == 7 && mc == 13) m_bytes = 0;
    win_int = (ln >= 78) && (ln < 80);
    e_int_n = !(m_en && win_int && (m_ack != f) && (SC != 2'b11));
    if (win_int && SC == 2'b11) m_ack = f;
    e_ef1_n = !(m_en && (((ln >= 76) && (ln < 80)) || ((ln >= 204) && (ln < 208))));
    e_de    = m_en && disp && win_dma;
    e_hs    = (mc >= 12);
    e_vs    = (ln < 4);
    if (io_n == 3'd1 && io_out) m_en = 0;
    else if (io_n == 3'd1 && io_inp) m_en = 1;
    m_n++;
  endtask

  task automatic tick();
    @(posedge CLOCK);
    model_edge();
    #1;
    chk1("dma_out_req", dma_out_req, e_req);
    chk1("int_n", int_n, e_int_n);
    chk1("ef1_n", ef1_n, e_ef1_n);
    chk1("pixel", pixel, e_pix);
    chk1("hsync", hsync, e_hs);
    chk1("vsync", vsync, e_vs);
    chk1("de", de, e_de);
  endtask

  // Background stimulus that never touches the display-enable port.
  task automatic set_rand_idle(input bit any_sc);
    int v;
    v = $urandom_range(0, 6);
    if (v >= 1) v++;
    io_n       = 3'(v);
    io_inp     = 1'($urandom);
    io_out     = 1'($urandom);
    dma_data   = 8'($urandom);
    dma_strobe = ($urandom % 8) == 0;
    SC         = any_sc ? 2'($urandom) : 2'($urandom % 2);
  endtask

  int  ln, mc, cd, p;
  int  hs_cnt, vs_cnt, req_cnt, int_cnt, ef1_cnt;
  int  pix_idx;
  logic [7:0] a5;

  initial begin
    vecs[0]  = '{0,   0,  5, 0, 1, 1, 1, 0, 0};
    vecs[1]  = '{3,  13,  7, 1, 1, 1, 1, 0, 0};
    vecs[2]  = '{4,   0,  0, 0, 0, 1, 1, 0, 0};
    vecs[3]  = '{75, 13,  7, 1, 0, 1, 1, 0, 0};
    vecs[4]  = '{76,  0,  0, 0, 0, 0, 1, 0, 0};
    vecs[5]  = '{77, 13,  7, 1, 0, 0, 1, 0, 0};
    vecs[6]  = '{78,  0,  0, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{79, 13,  7, 1, 0, 0, 1, 0, 0};
    vecs[8]  = '{80,  0,  0, 0, 0, 1, 1, 0, 0};
    vecs[9]  = '{80,  2,  0, 0, 0, 1, 1, 1, 1};
    vecs[10] = '{80,  9,  7, 0, 0, 1, 1, 1, 0};
    vecs[11] = '{80, 10,  0, 0, 0, 1, 1, 0, 0};
    vecs[12] = '{80, 12,  0, 1, 0, 1, 1, 0, 0};
    vecs[13] = '{151, 5,  0, 0, 0, 1, 1, 0, 0};
    vecs[14] = '{204, 0,  0, 0, 0, 0, 1, 0, 0};
    vecs[15] = '{207, 11, 0, 0, 0, 0, 1, 0, 0};
    vecs[16] = '{208, 0,  0, 0, 0, 1, 1, 0, 0};
    vecs[17] = '{240, 2,  0, 0, 0, 1, 1, 0, 0};
    a5 = 8'hA5;
    pix_idx = 64;
    model_reset();

    // Reset.
    CLEAR_N = 1'b0;
    set_rand_idle(1'b1);
    tick();
    tick();
    chkn("reset_bytecnt", 32'(dut.bytecnt_q), 0);
    CLEAR_N = 1'b1;

    // Frame 0: display disabled, random bus activity.
    hs_cnt = 0; vs_cnt = 0; req_cnt = 0; int_cnt = 0; ef1_cnt = 0;
    for (int k = 0; k < FRAME_CLKS; k++) begin
      cd = m_n % 8; mc = (m_n / 8) % 14;
      set_rand_idle(1'b1);
      tick();
      hs_cnt  += int'(hsync);
      vs_cnt  += int'(vsync);
      req_cnt += int'(dma_out_req);
      int_cnt += int'(!int_n);
      ef1_cnt += int'(!ef1_n);
      if (cd == 7 && mc == 13) begin
        chkn("hsync_per_line", hs_cnt, 16);
        hs_cnt = 0;
      end
    end
    chkn("vsync_clocks", vs_cnt, 4 * 112);
    chkn("req_while_off", req_cnt, 0);
    chkn("int_while_off", int_cnt, 0);
    chkn("ef1_while_off", ef1_cnt, 0);

    // Frame 1: enabled at frame start, directed and random DMA traffic.
    set_rand_idle(1'b0);
    io_n = 3'd1; io_inp = 1'b1; io_out = 1'b0;
    tick();
    while (m_n < 2 * FRAME_CLKS) begin
      p = m_n % FRAME_CLKS;
      ln = p / 112; mc = (p / 8) % 14; cd = p % 8;
      set_rand_idle(1'b0);
      if (ln >= 83 && ln < 208 && mc >= 2 && mc < 10) begin
        dma_strobe = ($urandom % 3) == 0;
        SC         = ($urandom % 2 == 0) ? 2'b10 : 2'($urandom);
      end
      if (ln == 50 && mc == 5 && cd == 3) begin
        dma_strobe = 1'b1; SC = 2'b10; dma_data = 8'hFF;
      end
      if (ln == 78 && mc == 5 && cd == 0) begin
        chk1("int_n_before_ack", int_n, 1'b0);
        SC = 2'b11;
      end
      if (ln == 80 && mc >= 2 && mc <= 9 && cd == 3) begin
        dma_strobe = 1'b1; SC = 2'b10; dma_data = 8'hA5;
      end
      if (ln == 80 && mc == 2 && cd == 3) pix_idx = 0;
      if (ln == 81 && mc >= 2 && mc <= 6 && cd == 3) begin
        dma_strobe = 1'b1; SC = 2'b10;
      end
      if (ln == 82 && mc >= 2 && mc <= 9 && cd == 3) begin
        dma_strobe = 1'b1; SC = 2'b01;
      end
      if (ln == 150 && mc == 5 && cd == 0) begin
        io_n = 3'd1; io_inp = 1'b0; io_out = 1'b1;
      end
      if (ln == 152 && mc == 3 && cd == 0) begin
        io_n = 3'd1; io_inp = 1'b1; io_out = 1'b0;
      end
      if (ln == 230 && mc == 0 && cd == 0) begin
        io_n = 3'd1; io_inp = 1'b1; io_out = 1'b1;
      end
      tick();

      for (int i = 0; i < NV; i++) begin
        if (vecs[i].ln == ln && vecs[i].mc == mc && vecs[i].cd == cd) begin
          chk1("vec_hsync", hsync, vecs[i].hs);
          chk1("vec_vsync", vsync, vecs[i].vs);
          chk1("vec_ef1_n", ef1_n, vecs[i].ef1_n);
          chk1("vec_int_n", int_n, vecs[i].int_n);
          chk1("vec_de", de, vecs[i].de);
          chk1("vec_req", dma_out_req, vecs[i].req);
        end
      end
      if (pix_idx < 64) begin
        chk1("a5_pixel", pixel, a5[3'(7 - (pix_idx % 8))]);
        pix_idx++;
      end
      if (ln == 50 && mc == 5 && cd == 3) begin
        chk1("line50_pixel", pixel, 1'b0);
        chkn("line50_bytecnt", 32'(dut.bytecnt_q), 0);
      end
      if (ln == 78 && mc == 5 && cd == 0) chk1("int_n_after_ack", int_n, 1'b1);
      if (ln == 80 && mc == 8 && cd == 3) chk1("req_before_8th", dma_out_req, 1'b1);
      if (ln == 80 && mc == 9 && cd == 3) chk1("req_after_8th", dma_out_req, 1'b0);
      if (ln == 81 && mc == 9 && cd == 7) chk1("req_5byte_mc9", dma_out_req, 1'b1);
      if (ln == 81 && mc == 10 && cd == 0) chk1("req_5byte_mc10", dma_out_req, 1'b0);
      if (ln == 81 && mc == 13 && cd == 6) chkn("bytecnt_5", 32'(dut.bytecnt_q), 5);
      if (ln == 82 && mc == 0 && cd == 0) chkn("bytecnt_newline", 32'(dut.bytecnt_q), 0);
      if (ln == 82 && mc >= 2 && mc <= 9 && cd == 3) begin
        chk1("sc01_pixel", pixel, 1'b0);
        chkn("sc01_bytecnt", 32'(dut.bytecnt_q), 0);
      end
      if (ln == 230 && mc == 0 && cd == 0) chk1("both_strobes_en", dut.en_q, 1'b0);
    end

    // Frame 2: enable, load one byte on line 80, then reset mid-byte.
    set_rand_idle(1'b0);
    io_n = 3'd1; io_inp = 1'b1; io_out = 1'b0;
    tick();
    while (m_n < 2 * FRAME_CLKS + 80 * 112 + 2 * 8 + 3) begin
      set_rand_idle(1'b0);
      tick();
    end
    set_rand_idle(1'b0);
    dma_strobe = 1'b1; SC = 2'b10; dma_data = 8'hC3;
    tick();
    chk1("c3_first_pixel", pixel, 1'b1);
    for (int k = 0; k < 3; k++) begin
      set_rand_idle(1'b0);
      tick();
    end
    set_rand_idle(1'b1);
    CLEAR_N = 1'b0;
    tick();
    chk1("clear_pixel", pixel, 1'b0);
    chkn("clear_line", 32'(dut.u_timing.line_q), 0);
    CLEAR_N = 1'b1;
    for (int k = 0; k < 24; k++) begin
      set_rand_idle(1'b1);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
